// File: rtl/cic_pkg.sv
// cic_pkg: shared types and helpers for the CIC decimator.
// Mode encodings, FSM states and accumulator sizing.
package cic_pkg;

  localparam logic MODE_INCR = 1'b0;
  localparam logic MODE_CONT = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_INTEG
  } state_t;

  // Worst-case growth of an ORDER-stage chain at the largest ratio
  function automatic int acc_bits(input int order,
                                  input int max_log2_r);
    return order * max_log2_r + 1;
  endfunction

endpackage

// File: rtl/cic_if.sv
// cic_if: sample/config inputs and result outputs of the decimator.
// master drives samples and config, slave returns results.
interface cic_if
  import cic_pkg::*;
#(
  parameter int MAX_LOG2_R = 6,
  parameter int OUT_BITS   = 16
);

  localparam int LW = $clog2(MAX_LOG2_R + 1);

  logic                in_valid;
  logic                x;
  logic                mode;
  logic [LW-1:0]       log2_r;
  logic                start;
  logic                busy;
  logic                out_valid;
  logic [OUT_BITS-1:0] z;

  modport master (
    output in_valid,
    output x,
    output mode,
    output log2_r,
    output start,
    input  busy,
    input  out_valid,
    input  z
  );

  modport slave (
    input  in_valid,
    input  x,
    input  mode,
    input  log2_r,
    input  start,
    output busy,
    output out_valid,
    output z
  );

endinterface

// File: rtl/cic_integrator_chain.sv
// cic_integrator_chain: ORDER cascaded accumulators, modulo 2^W.
// i_out is the last stage including the sample of this cycle.
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int ORDER = 2,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         x,
  output logic [W-1:0] i_out
);

  logic [W-1:0] acc_q [ORDER];
  logic [W-1:0] acc_d [ORDER];

  // Updated values ripple down the cascade in one cycle
  always_comb begin
    logic [W-1:0] s;
    s = W'(x);
    for (int k = 0; k < ORDER; k++) begin
      s        = acc_q[k] + s;
      acc_d[k] = s;
    end
  end

  assign i_out = acc_d[ORDER-1];

  // Clear has priority over accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < ORDER; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: CIC decimator for 1-bit delta-sigma streams.
// Incremental one-shot or continuous mode, runtime 2^n ratio.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int ORDER      = 2,
  parameter int MAX_LOG2_R = 6,
  parameter int OUT_BITS   = 16
) (
  input  logic clk,
  input  logic reset,
  cic_if.slave bus
);

  localparam int ACC_BITS = acc_bits(ORDER, MAX_LOG2_R);
  localparam int LW       = $clog2(MAX_LOG2_R + 1);
  localparam int CW       = MAX_LOG2_R;
  localparam int SW       = $clog2(ORDER + 1);

  if (OUT_BITS < ACC_BITS) begin : g_bad_width
    $fatal(1, "cic_decimator: OUT_BITS smaller than ACC_BITS");
  end

  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $fatal(1, "cic_decimator: ORDER outside 1..4");
  end

  if (MAX_LOG2_R < 1) begin : g_bad_ratio
    $fatal(1, "cic_decimator: MAX_LOG2_R must be >= 1");
  end

  logic                init_q;
  logic                mode_q;
  logic [LW-1:0]       l2_q;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [SW-1:0]       settle_q;
  logic [ACC_BITS-1:0] comb_q [ORDER];
  logic [OUT_BITS-1:0] z_q;
  logic                ov_q;

  logic [LW-1:0]       l2_eff;
  logic [CW-1:0]       r_m1;
  logic                cont;
  logic                flush;
  logic                last;
  logic                samp;
  logic                en;
  logic                fire;
  logic                clr;
  logic                settled;
  logic [ACC_BITS-1:0] i_out;
  logic [ACC_BITS-1:0] comb_in [ORDER];
  logic [ACC_BITS-1:0] comb_out;

  assign l2_eff = (l2_q > LW'(MAX_LOG2_R)) ? LW'(MAX_LOG2_R)
                                           : l2_q;
  assign r_m1   = CW'((32'd1 << l2_eff) - 32'd1);

  assign cont  = (mode_q == MODE_CONT);
  assign flush = !init_q
              || (bus.mode != mode_q)
              || (bus.log2_r != l2_q);
  assign last  = (cnt_q == r_m1);

  // Incremental: a start drops its sample unless it ends a run
  assign samp = cont ? bus.in_valid
              : ((state_q == ST_INTEG) && bus.in_valid
                 && (!bus.start || last));

  assign en      = samp && !flush;
  assign fire    = en && last;
  assign clr     = flush || (!cont && bus.start);
  assign settled = (settle_q == SW'(ORDER));

  cic_integrator_chain #(
    .ORDER (ORDER),
    .W     (ACC_BITS)
  ) u_integ (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .x     (bus.x),
    .i_out (i_out)
  );

  // Comb cascade: each stage subtracts its stored input
  always_comb begin
    logic [ACC_BITS-1:0] c;
    c = i_out;
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = c;
      c          = c - comb_q[k];
    end
    comb_out = c;
  end

  // Config shadows; a mismatch (or first cycle) forces a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q <= 1'b0;
      mode_q <= MODE_INCR;
      l2_q   <= '0;
    end else if (flush) begin
      init_q <= 1'b1;
      mode_q <= bus.mode;
      l2_q   <= bus.log2_r;
    end
  end

  // Accepted-sample counter, wraps at R-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  // Comb delay lines and fill count for continuous mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
      for (int k = 0; k < ORDER; k++) comb_q[k] <= '0;
    end else if (flush) begin
      settle_q <= '0;
      for (int k = 0; k < ORDER; k++) comb_q[k] <= '0;
    end else if (cont && fire) begin
      for (int k = 0; k < ORDER; k++) comb_q[k] <= comb_in[k];
      if (!settled) settle_q <= settle_q + 1'b1;
    end
  end

  // Conversion FSM and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      z_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
      end else if (cont) begin
        if (fire && settled) begin
          z_q  <= OUT_BITS'(comb_out);
          ov_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.start) state_q <= ST_INTEG;
          end
          ST_INTEG: begin
            if (fire) begin
              z_q     <= OUT_BITS'(i_out);
              ov_q    <= 1'b1;
              state_q <= bus.start ? ST_INTEG : ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = cont || (state_q == ST_INTEG);
  assign bus.out_valid = ov_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: randomized and directed bench for cic_decimator.
// Reference uses binomial-weighted sums over the accepted samples.
module tb_cic_decimator;
  import cic_pkg::*;

  localparam int     ORDER = 2;
  localparam int     MAXL  = 6;
  localparam int     OB    = 16;
  localparam int     ACC   = ORDER * MAXL + 1;
  localparam longint MASK  = (longint'(1) << ACC) - 1;
  localparam bit     H     = 1'b1;
  localparam bit     L     = 1'b0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ov_total = 0;
  int   base;

  cic_if #(.MAX_LOG2_R(MAXL), .OUT_BITS(OB)) bus ();

  cic_decimator #(
    .ORDER      (ORDER),
    .MAX_LOG2_R (MAXL),
    .OUT_BITS   (OB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference state
  bit m_init = 0;
  bit m_mode = 0;
  int m_l2   = 0;
  bit m_conv = 0;
  int m_dec  = 0;
  int m_r;
  int m_n;
  bit q[$];
  bit exp_valid = 0;
  int exp_z     = 0;
  bit exp_busy  = 0;

  function automatic longint binom(input longint n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // ORDER-fold running sum of the first n accepted samples
  function automatic longint integ(input int n);
    longint s = 0;
    for (int j = 1; j <= n; j++)
      if (q[j-1]) s += binom(n - j + ORDER - 1, ORDER - 1);
    return s;
  endfunction

  // ORDER-th difference of the decimated sequence, zero history
  function automatic longint comb_val(input int n, input int r);
    longint s = 0;
    for (int i = 0; i <= ORDER; i++) begin
      if (n - i * r > 0) begin
        if (i % 2 == 1) s -= binom(ORDER, i) * integ(n - i * r);
        else            s += binom(ORDER, i) * integ(n - i * r);
      end
    end
    return s & MASK;
  endfunction

  task automatic chk(input string nm, input longint got,
                     input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, got, want, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_init = 0; m_mode = 0; m_l2 = 0; m_conv = 0; m_dec = 0;
      q.delete();
      exp_valid = 0; exp_z = 0; exp_busy = 0;
    end else begin
      exp_valid = 0;
      if (!m_init || bus.mode != m_mode
          || int'(bus.log2_r) != m_l2) begin
        m_init = 1;
        m_mode = bus.mode;
        m_l2   = int'(bus.log2_r);
        q.delete();
        m_conv = 0;
        m_dec  = 0;
      end else begin
        m_r = 1 << (m_l2 > MAXL ? MAXL : m_l2);
        if (m_mode) begin
          if (bus.in_valid) begin
            q.push_back(bus.x);
            m_n = q.size();
            if (m_n % m_r == 0) begin
              m_dec++;
              if (m_dec > ORDER) begin
                exp_valid = 1;
                exp_z     = int'(comb_val(m_n, m_r));
              end
            end
          end
        end else if (!m_conv) begin
          if (bus.start) begin
            m_conv = 1;
            q.delete();
          end
        end else if (bus.in_valid
                     && (!bus.start || q.size() + 1 == m_r)) begin
          q.push_back(bus.x);
          if (q.size() == m_r) begin
            exp_valid = 1;
            exp_z     = int'(integ(m_r) & MASK);
            m_conv    = bus.start;
            q.delete();
          end
        end else if (bus.start) begin
          q.delete();
        end
      end
      exp_busy = m_mode || m_conv;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, exp_valid);
    chk("busy", bus.busy, exp_busy);
    chk("z", bus.z, exp_z);
    if (bus.out_valid) ov_total++;
  end

  task automatic drive(input bit iv, input bit xx, input bit st);
    @(negedge clk);
    bus.in_valid = iv;
    bus.x        = xx;
    bus.start    = st;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(L, L, L);
  endtask

  task automatic cfg(input bit md, input int l2);
    drive(L, L, L);
    bus.mode   = md;
    bus.log2_r = l2[2:0];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.x = 0; bus.start = 0;
    bus.mode = 0; bus.log2_r = 3'd4;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(3);

    // 1: incremental, R=16, all ones
    #1 base = ov_total;
    drive(L, L, H);
    repeat (16) drive(H, H, L);
    idle(3);
    #1;
    chk("t1_z", bus.z, 136);
    chk("t1_model", exp_z, 136);
    chk("t1_busy", bus.busy, 0);
    chk("t1_pulses", ov_total - base, 1);

    // 2: alternating bits, in_valid every third cycle
    drive(L, L, H);
    for (int i = 0; i < 48; i++)
      drive(i % 3 == 2, (i % 3 == 2) && ((i / 3) % 2 == 0), L);
    drive(L, L, L);
    chk("t2_lat", bus.out_valid, 1);
    idle(2);
    chk("t2_z", bus.z, 72);

    // 3: continuous, R=16, all ones, integrators wrap
    cfg(H, 4);
    #1 base = ov_total;
    repeat (1632) drive(H, H, L);
    drive(L, L, L);
    #1;
    chk("t3_z", bus.z, 256);
    chk("t3_pulses", ov_total - base, 100);

    // 4: continuous, R=4, zeros then ones
    cfg(H, 2);
    repeat (8) drive(H, L, L);
    repeat (40) drive(H, H, L);
    idle(2);
    chk("t4_z", bus.z, 16);

    // random traffic, config churn incl. clamped ratio
    cfg(L, 3);
    for (int i = 0; i < 2500; i++) begin
      drive($urandom % 4 != 0, 1'($urandom % 2),
            $urandom % 30 == 0);
      if ($urandom % 150 == 0) bus.mode = 1'($urandom % 2);
      if ($urandom % 150 == 0)
        bus.log2_r = 3'($urandom_range(7, 0));
    end

    // 5: config changes mid-conversion and mid-stream
    cfg(L, 4);
    idle(2);
    drive(L, L, H);
    repeat (16) drive(H, H, L);
    idle(2);
    chk("t5_pre", bus.z, 136);
    drive(L, L, H);
    repeat (15) drive(H, H, L);
    drive(H, H, L);
    bus.log2_r = 3'd3;
    drive(H, H, L);
    chk("t5_ov", bus.out_valid, 0);
    chk("t5_z", bus.z, 136);
    chk("t5_busy", bus.busy, 0);
    repeat (4) drive(H, H, L);
    bus.mode = 1'b1;
    repeat (20) drive(H, H, L);
    bus.mode = 1'b0;
    drive(H, H, L);
    chk("t5_ov2", bus.out_valid, 0);
    chk("t5_z2", bus.z, 136);
    idle(2);
    drive(L, L, H);
    repeat (8) drive(H, H, L);
    idle(2);
    chk("t5_r8", bus.z, 36);
    chk("t5_model", exp_z, 36);

    // 6: async reset mid-conversion
    cfg(L, 4);
    idle(2);
    drive(L, L, H);
    repeat (6) drive(H, H, L);
    #2;
    bus.in_valid = 0;
    bus.x = 0;
    reset = 1'b1;
    #1;
    chk("t6_rst_z", bus.z, 0);
    chk("t6_rst_ov", bus.out_valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    drive(L, L, H);
    repeat (16) drive(H, H, L);
    idle(2);
    chk("t6_z", bus.z, 136);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
